// File: rtl/reg_dump_unit_pkg.sv
// reg_dump_unit_pkg: shared state encoding and word/byte sizing helpers for the register dump unit.
package reg_dump_unit_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic int bytes_per_word(input int data_length, input int byte_width);
        return data_length / byte_width;
    endfunction

    function automatic int cnt_width(input int bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: walks the register bank and streams every word MSB-byte-first to a UART transmitter,
// holding the pipeline halted (o_busy) for the whole dump.
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int BANK_SIZE   = 32,
    parameter int ADDR_LENGTH = 5,
    parameter int DATA_LENGTH = 32,
    parameter int BYTE_WIDTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    output logic [ADDR_LENGTH-1:0] o_reg_addr,
    input  logic [DATA_LENGTH-1:0] i_reg_data,
    output logic [BYTE_WIDTH-1:0]  o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BPW = bytes_per_word(DATA_LENGTH, BYTE_WIDTH);
    localparam int CW  = cnt_width(BPW);
    localparam logic [CW-1:0]          LAST_BYTE = CW'(BPW - 1);
    localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(BANK_SIZE - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [DATA_LENGTH-1:0] r_word;
    logic [DATA_LENGTH-1:0] w_shift;
    logic [CW-1:0]          r_byte_cnt;
    logic                   w_last_byte;
    logic                   w_last_addr;

    assign w_shift     = r_word << BYTE_WIDTH;
    assign w_last_byte = r_byte_cnt == LAST_BYTE;
    assign w_last_addr = o_reg_addr == LAST_ADDR;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? ADDR : IDLE;
            ADDR:    w_next = LOAD;
            LOAD:    w_next = SEND;
            SEND:    w_next = WAIT_TX;
            WAIT_TX: w_next = !i_tx_done ? WAIT_TX : !w_last_byte ? SEND : w_last_addr ? DONE : ADDR;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Strobes are decoded from the next state so they are registered yet aligned with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_reg_addr <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            r_word     <= '0;
            r_byte_cnt <= '0;
        end else begin
            o_tx_start <= w_next == SEND;
            o_busy     <= w_next != IDLE;
            o_done     <= w_next == DONE;
            case (r_state)
                IDLE: if (i_start) o_reg_addr <= '0;
                LOAD: begin
                    r_word     <= i_reg_data;
                    r_byte_cnt <= '0;
                    o_tx_data  <= i_reg_data[DATA_LENGTH-1 -: BYTE_WIDTH];
                end
                WAIT_TX: begin
                    if (i_tx_done && !w_last_byte) begin
                        r_word     <= w_shift;
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                        o_tx_data  <= w_shift[DATA_LENGTH-1 -: BYTE_WIDTH];
                    end else if (i_tx_done && !w_last_addr) begin
                        o_reg_addr <= o_reg_addr + ADDR_LENGTH'(1);
                    end
                end
                DONE: o_reg_addr <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: randomized self-checking bench; a bank array plus transmitter responder feed the DUT
// and the captured byte stream is compared with the stream predicted from the bank contents.
module tb_reg_dump_unit;

    localparam int NREG  = 32;
    localparam int BPW   = 4;
    localparam int NBYTE = NREG * BPW;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  o_reg_addr;
    logic [31:0] w_reg_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done = 1'b0;
    logic        o_busy;
    logic        o_done;

    logic [31:0] bank [NREG];
    assign w_reg_data = bank[o_reg_addr];

    reg_dump_unit dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_reg_addr (o_reg_addr),
        .i_reg_data (w_reg_data),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q [$];
    int         addr_q [$];
    int         pend [$];
    int first_start, first_busy, done_cnt, done_cyc, last_txd, busy_cnt, t_start;
    int dly_min = 4, dly_max = 4, dly_cur = 4, hold = 1;
    bit same_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = bank[i / BPW] >> (8 * (BPW - 1 - i % BPW));
        return w[7:0];
    endfunction

    // Monitor and transmitter model: sample outputs, then schedule/drive i_tx_done for this cycle.
    initial begin
        forever begin
            bit txd;
            @(negedge clk);
            if (o_tx_start) begin
                got_q.push_back(o_tx_data);
                addr_q.push_back(int'(o_reg_addr));
                if (first_start < 0) first_start = cyc;
                pend.push_back(cyc + dly_cur);
                if (same_mode) pend.push_back(cyc);
                dly_cur = $urandom_range(dly_max, dly_min);
            end
            if (o_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            txd = 0;
            for (int k = pend.size() - 1; k >= 0; k--) begin
                if (pend[k] <= cyc && cyc < pend[k] + hold) txd = 1;
                if (pend[k] + hold <= cyc) pend.delete(k);
            end
            i_tx_done = txd;
            if (txd && o_busy) last_txd = cyc;
        end
    end

    task automatic set_tx(input int dmin, input int dmax, input int h, input bit same);
        dly_min = dmin;
        dly_max = dmax;
        dly_cur = $urandom_range(dmax, dmin);
        hold = h;
        same_mode = same;
    endtask

    task automatic fill_bank(input bit pattern);
        for (int n = 0; n < NREG; n++) bank[n] = pattern ? 32'h11223300 + 32'(n) : $urandom;
    endtask

    task automatic start_dump();
        @(negedge clk);
        got_q.delete();
        addr_q.delete();
        first_start = -1;
        first_busy = -1;
        done_cnt = 0;
        done_cyc = -1;
        last_txd = -1;
        busy_cnt = 0;
        t_start = cyc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n);
        int k = 0;
        while (got_q.size() < n && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("wait_bytes", 32'(got_q.size() >= n), 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 32'(done_cnt != 0), 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_len"}, got_q.size(), NBYTE);
        n = got_q.size() < NBYTE ? got_q.size() : NBYTE;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_byte(i));
            check($sformatf("%s_addr%0d", tag, i), addr_q[i], i / BPW);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_span"}, busy_cnt, done_cyc - first_busy + 1);
        check({tag, "_idle_busy"}, o_busy, 0);
        check({tag, "_idle_addr"}, o_reg_addr, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, o_reg_addr, 0);
        check({tag, "_data"}, o_tx_data, 0);
        check({tag, "_start"}, o_tx_start, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b1;
        fill_bank(1);
        repeat (3) @(negedge clk);
        check_zero("rst");
        i_start = 1'b0;
        i_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("post_rst");

        set_tx(4, 4, 1, 0);
        start_dump();
        wait_done();
        check_stream("pattern");
        check("lat_busy", first_busy - t_start, 1);
        check("lat_start", first_start - t_start, 3);
        check("lat_done", done_cyc - last_txd, 1);

        fill_bank(0);
        set_tx(3, 3, 1, 1);
        start_dump();
        wait_done();
        check_stream("same_cycle");

        fill_bank(0);
        set_tx(4, 4, 5, 0);
        start_dump();
        wait_done();
        check_stream("hold5");

        fill_bank(0);
        set_tx(1, 6, 1, 0);
        start_dump();
        wait_bytes(10 * BPW + 1);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done();
        check_stream("start_busy");

        for (int r = 0; r < 2; r++) begin
            fill_bank(0);
            set_tx(1, 8, $urandom_range(2, 1), 0);
            start_dump();
            wait_done();
            check_stream($sformatf("rand%0d", r));
        end

        fill_bank(1);
        set_tx(4, 4, 1, 0);
        start_dump();
        wait_bytes(7 * BPW + 3);
        @(posedge clk);
        #2;
        i_rst = 1'b1;
        pend.delete();
        #1;
        check_zero("async_rst");
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        i_rst = 1'b0;
        start_dump();
        wait_done();
        check_stream("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
